// File: rtl/fetch_queue.sv
// Purpose : in-order decoupling FIFO between the instruction cache and decode (PC + instruction word).
// Latency : 1 cycle push-to-out_valid; 0 cycles with FETCH_QUEUE_BYPASS_EN defined and the queue empty.
// Backpressure: in_ready drops when full (registered, no out_ready path); decode stalls are absorbed.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               discard every buffered entry this cycle (branch redirect)
//   in_valid/in_ready   cache-side handshake carrying in_pc, in_instr
//   out_valid/out_ready decode-side handshake carrying out_pc, out_instr (zero when empty)
//   occupancy           registered entry count
// Optional macro: FETCH_QUEUE_BYPASS_EN -- empty-queue combinational bypass from input to output.
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [ADDR_WIDTH-1:0]      in_pc,
    input  logic [DATA_WIDTH-1:0]      in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [ADDR_WIDTH-1:0]      out_pc,
    output logic [DATA_WIDTH-1:0]      out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic empty;
    logic push;
    logic pop;

    assign empty     = (count == '0);
    assign in_ready  = (count != FULL_CNT);
    assign occupancy = count;

    // Pop only ever takes a stored entry; a bypassed instruction never touches storage.
    assign pop = ~empty & out_ready & ~flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic byp;
    assign byp = empty & in_valid & ~flush;
    // A bypassed instruction consumed by decode this cycle is not written.
    assign push = in_valid & in_ready & ~flush & ~(byp & out_ready);
`else
    assign push = in_valid & in_ready & ~flush;
`endif

    always_comb begin
        out_valid = ~empty;
        out_pc    = '0;
        out_instr = '0;
        if (!empty) begin
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (byp) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
        end
`endif
    end

    // Slot contents carry no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
